// File: rtl/sram_uart_pkg.sv
// ============================================================================
// sram_uart_pkg: UART register map and FSM states shared by the SRAM loader
// and the SRAM dumper.  Rev 1.0
// ============================================================================
`default_nettype none

package sram_uart_pkg;

    localparam int RX_BASE     = 0;
    localparam int TX_BASE     = 4;
    localparam int STATUS_BASE = 8;
    localparam int RX_OK_BIT   = 7;
    localparam int TX_OK_BIT   = 6;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SRAM = 3'd1,
        S_POLL = 3'd2,
        S_SEND = 3'd3,
        S_DONE = 3'd4
    } dump_state_t;

endpackage

`default_nettype wire

// File: rtl/sram_uart_dumper.sv
// ============================================================================
// sram_uart_dumper: streams a block of 16-bit SRAM words out of the UART,
// high byte first.  Rev 1.0
// ============================================================================
`default_nettype none

module sram_uart_dumper
    import sram_uart_pkg::dump_state_t;
    import sram_uart_pkg::S_IDLE;
    import sram_uart_pkg::S_SRAM;
    import sram_uart_pkg::S_POLL;
    import sram_uart_pkg::S_SEND;
    import sram_uart_pkg::S_DONE;
#(
    parameter int ADDR_W      = 20,
    parameter int TX_BASE     = sram_uart_pkg::TX_BASE,
    parameter int STATUS_BASE = sram_uart_pkg::STATUS_BASE,
    parameter int TX_OK_BIT   = sram_uart_pkg::TX_OK_BIT
) (
    input  logic              avm_rst,
    input  logic              avm_clk,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [ADDR_W:0]   i_len,
    output logic              o_busy,
    output logic              o_done,
    input  logic              avm_waitrequest,
    output logic [4:0]        avm_address,
    output logic              avm_read,
    input  logic [31:0]       avm_readdata,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic [ADDR_W-1:0] o_addr,
    inout  wire  [15:0]       io_data,
    output logic              o_we_n,
    output logic              o_ce_n,
    output logic              o_oe_n,
    output logic              o_lb_n,
    output logic              o_ub_n
);

    localparam logic [4:0] TX_ADDR     = 5'(TX_BASE);
    localparam logic [4:0] STATUS_ADDR = 5'(STATUS_BASE);

    dump_state_t       state;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W:0]   len;
    logic [ADDR_W:0]   cnt;
    logic [15:0]       word_r;
    logic              byte_sel;
    logic [1:0]        wait_cnt;
    logic              unused_readdata;

    // Read-only SRAM master: the data bus is never driven from this side.
    assign io_data = {16{1'bz}};
    assign o_addr  = base + cnt[ADDR_W-1:0];
    assign o_we_n  = 1'b1;
    assign o_ce_n  = 1'b0;
    assign o_lb_n  = 1'b0;
    assign o_ub_n  = 1'b0;
    assign o_oe_n  = (state != S_SRAM);

    assign unused_readdata = ^avm_readdata;

    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            state         <= S_IDLE;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            avm_address   <= STATUS_ADDR;
            avm_writedata <= '0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            base          <= '0;
            len           <= '0;
            cnt           <= '0;
            word_r        <= '0;
            byte_sel      <= 1'b0;
            wait_cnt      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        base     <= i_base;
                        len      <= i_len;
                        cnt      <= '0;
                        wait_cnt <= '0;
                        o_done   <= 1'b0;
                        o_busy   <= 1'b1;
                        state    <= (i_len == '0) ? S_DONE : S_SRAM;
                    end
                end
                S_SRAM: begin
                    // Address has been stable since entry; third cycle samples the data.
                    if (wait_cnt == 2'd2) begin
                        word_r      <= io_data;
                        byte_sel    <= 1'b0;
                        wait_cnt    <= '0;
                        avm_read    <= 1'b1;
                        avm_address <= STATUS_ADDR;
                        state       <= S_POLL;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                S_POLL: begin
                    // Read stays asserted while TX is full, so each accepted cycle is a fresh poll.
                    if (!avm_waitrequest && avm_readdata[TX_OK_BIT]) begin
                        avm_read      <= 1'b0;
                        avm_write     <= 1'b1;
                        avm_address   <= TX_ADDR;
                        avm_writedata <= {24'b0, byte_sel ? word_r[7:0] : word_r[15:8]};
                        state         <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (!avm_waitrequest) begin
                        avm_write   <= 1'b0;
                        avm_address <= STATUS_ADDR;
                        if (!byte_sel) begin
                            byte_sel <= 1'b1;
                            avm_read <= 1'b1;
                            state    <= S_POLL;
                        end else if (cnt + 1'b1 == len) begin
                            state <= S_DONE;
                        end else begin
                            cnt   <= cnt + 1'b1;
                            state <= S_SRAM;
                        end
                    end
                end
                S_DONE: begin
                    o_busy <= 1'b0;
                    o_done <= 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
